// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch unit and its FIFOs.
package ifu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_RESET_WAIT,
        ST_FETCH,
        ST_DRAIN
    } ifu_state_t;

    function automatic logic [31:0] imem_address(input logic [31:0] pc, input bit word_addressed);
        return word_addressed ? {2'b00, pc[31:2]} : pc;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush, occupancy count and a registered head entry.
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    // Explicit wrap keeps non-power-of-two depths (e.g. 3 outstanding) legal.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (32'(p) == 32'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= wrap_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= wrap_inc(r_rd_ptr);
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front-end: credit-limited imem issue, prefetch FIFO, redirect with stale-response drop.
// Optional misaligned-redirect fault entry enabled by defining IFU_MISALIGN_CHECK_EN.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS    = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          WORD_ADDRESSED  = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
`ifdef IFU_MISALIGN_CHECK_EN
    localparam int ENTRY_W = $bits(fetch_entry_t);
`else
    localparam int ENTRY_W = 64;
`endif

    ifu_state_t       r_state;
    ifu_state_t       w_state_nxt;
    logic [31:0]      r_pc;
    logic [OW-1:0]    r_drop_cnt;
    logic [OW-1:0]    w_drop_nxt;
    logic [OW-1:0]    w_outstanding;
    logic [OW-1:0]    w_out_nxt;
    logic [CW-1:0]    w_fifo_count;
    logic [31:0]      w_rsp_pc;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head;
    logic             w_req_valid;
    logic             w_accept;
    logic             w_drop;
    logic             w_rsp_keep;
    logic             w_push;
    logic             w_pop;
    logic             w_halt;
    logic [31:0]      w_redirect_target;

    // Outstanding count is the PC queue occupancy: pushed on accept, popped on every response.
    assign w_req_valid = (r_state != ST_RESET_WAIT) && !w_halt
                      && (32'(w_fifo_count) + 32'(w_outstanding) < 32'(DEPTH))
                      && (32'(w_outstanding) < 32'(MAX_OUTSTANDING));
    assign w_accept    = w_req_valid && imem_req_ready;
    assign w_out_nxt   = w_outstanding + OW'(w_accept) - OW'(imem_rsp_valid);
    assign w_drop      = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_keep  = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop       = if_valid && if_ready;

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = imem_address(r_pc, WORD_ADDRESSED != 0);

`ifdef IFU_MISALIGN_CHECK_EN
    logic         r_halt;
    logic         r_fault_pend;
    logic         w_fault_push;
    fetch_entry_t w_entry;
    fetch_entry_t w_head_entry;

    assign w_redirect_target = redirect_pc;
    assign w_halt            = r_halt;
    assign w_fault_push      = r_fault_pend && (r_drop_cnt == '0) && !redirect_valid;
    assign w_push            = w_rsp_keep || w_fault_push;

    always_comb begin
        w_entry.pc    = w_rsp_pc;
        w_entry.instr = imem_rsp_data;
        w_entry.fault = 1'b0;
        if (w_fault_push) begin
            w_entry.pc    = r_pc;
            w_entry.instr = NOP_INSTR;
            w_entry.fault = 1'b1;
        end
    end

    assign w_push_data  = w_entry;
    assign w_head_entry = w_head;
    assign fetch_fault  = if_valid && w_head_entry.fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_halt       <= 1'b0;
            r_fault_pend <= 1'b0;
        end else if (redirect_valid) begin
            r_halt       <= (redirect_pc[1:0] != 2'b00);
            r_fault_pend <= (redirect_pc[1:0] != 2'b00);
        end else if (w_fault_push) begin
            r_fault_pend <= 1'b0;
        end
    end
`else
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign w_halt            = 1'b0;
    assign w_push            = w_rsp_keep;
    assign w_push_data       = {w_rsp_pc, imem_rsp_data};
    assign fetch_fault       = 1'b0;
`endif

    assign if_valid = (w_fifo_count != '0);
    assign if_pc    = w_head[ENTRY_W-1 -: 32];
    assign if_instr = w_head[ENTRY_W-33 -: 32];

    ifu_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_prefetch (
        .clk        (clk),
        .rst_n      (reset),
        .i_flush    (redirect_valid),
        .i_push     (w_push),
        .i_push_data(w_push_data),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_fifo_count)
    );

    ifu_fifo #(
        .WIDTH(32),
        .DEPTH(MAX_OUTSTANDING)
    ) u_pc_queue (
        .clk        (clk),
        .rst_n      (reset),
        .i_flush    (1'b0),
        .i_push     (w_accept),
        .i_push_data(r_pc),
        .i_pop      (imem_rsp_valid),
        .o_head     (w_rsp_pc),
        .o_count    (w_outstanding)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RESET_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect reloads drop_cnt with the post-edge outstanding count, overriding any drain in progress.
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_nxt = w_out_nxt;
        end else if (w_drop) begin
            w_drop_nxt = r_drop_cnt - 1'b1;
        end
        unique case (r_state)
            ST_RESET_WAIT: w_state_nxt = ST_FETCH;
            ST_FETCH:      if (redirect_valid && (w_out_nxt != '0)) w_state_nxt = ST_DRAIN;
            ST_DRAIN:      if (w_drop_nxt == '0) w_state_nxt = ST_FETCH;
            default:       w_state_nxt = ST_RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= BOOT_ADDRESS;
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_nxt;
            if (redirect_valid) begin
                r_pc <= w_redirect_target;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

endmodule
